tpu_axil_regs: RTL



---
 rtl/tpu_axil_pkg.sv | 19 +
 rtl/tpu_axil_regs.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tpu_axil_pkg.sv
// Shared constants for the TPU AXI4-Lite register block: register word
// indices, STATUS bit positions and the AXI response code.
package tpu_axil_pkg;

   localparam int REG_IDX_W   = 3;
   localparam int NUM_RW_REGS = 4;

   localparam logic [REG_IDX_W-1:0] REG_CTRL   = 3'd0;
   localparam logic [REG_IDX_W-1:0] REG_A_BASE = 3'd1;
   localparam logic [REG_IDX_W-1:0] REG_B_BASE = 3'd2;
   localparam logic [REG_IDX_W-1:0] REG_C_BASE = 3'd3;
   localparam logic [REG_IDX_W-1:0] REG_STATUS = 3'd4;

   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/tpu_axil_regs.sv
// AXI4-Lite slave register file for the TPU: four R/W control registers,
// a one-cycle start pulse on CTRL bit0 writes and a STATUS readback.
module tpu_axil_regs
   import tpu_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [2:0]                      s_axi_awprot,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   output logic [1:0]                      s_axi_bresp,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [2:0]                      s_axi_arprot,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                      s_axi_rresp,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   a_base_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   b_base_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   c_base_o,
   output logic                            start_o,
   input  logic                            busy_i,
   input  logic                            done_i
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int NB = C_S_AXI_DATA_WIDTH / 8;

   logic                           ready_en_reg;
   logic                           aw_held_reg;
   logic [REG_IDX_W-1:0]           aw_idx_reg;
   logic                           w_held_reg;
   logic [DW-1:0]                  w_data_reg;
   logic [NB-1:0]                  w_strb_reg;
   logic                           bvalid_reg;
   logic                           rvalid_reg;
   logic [DW-1:0]                  rdata_reg;
   logic                           start_reg;
   logic                           done_sticky_reg;

   logic [NUM_RW_REGS-1:0][DW-1:0] rw_regs;
   logic [DW-1:0]                  rd_data_next;
   logic [REG_IDX_W-1:0]           ar_idx;
   logic                           aw_hs;
   logic                           w_hs;
   logic                           ar_hs;
   logic                           wr_commit;
   logic                           start_next;
   logic                           status_clr;
   logic                           unused_bits;

   // ready_en keeps every ready low in the first cycle after reset
   assign s_axi_awready = ready_en_reg & ~aw_held_reg & ~bvalid_reg;
   assign s_axi_wready  = ready_en_reg & ~w_held_reg & ~bvalid_reg;
   assign s_axi_arready = ready_en_reg & ~rvalid_reg;
   assign s_axi_bvalid  = bvalid_reg;
   assign s_axi_bresp   = AXI_RESP_OKAY;
   assign s_axi_rvalid  = rvalid_reg;
   assign s_axi_rresp   = AXI_RESP_OKAY;
   assign s_axi_rdata   = rdata_reg;
   assign start_o       = start_reg;

   assign aw_hs     = s_axi_awvalid & s_axi_awready;
   assign w_hs      = s_axi_wvalid & s_axi_wready;
   assign ar_hs     = s_axi_arvalid & s_axi_arready;
   assign wr_commit = aw_held_reg & w_held_reg;
   assign ar_idx    = s_axi_araddr[2 +: REG_IDX_W];

   assign start_next = wr_commit && (aw_idx_reg == REG_CTRL) &&
                       w_strb_reg[0] && w_data_reg[0];
   assign status_clr = wr_commit && (aw_idx_reg == REG_STATUS) &&
                       w_strb_reg[0] && w_data_reg[STATUS_DONE_BIT];

   assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                          s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RW_REGS; gi++) begin : g_rw_reg
         logic [DW-1:0] value_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               value_reg <= '0;
            end else if (wr_commit && (aw_idx_reg == REG_IDX_W'(gi))) begin
               for (int bi = 0; bi < NB; bi++) begin
                  if (w_strb_reg[bi]) begin
                     value_reg[bi*8 +: 8] <= w_data_reg[bi*8 +: 8];
                  end
               end
            end
         end

         assign rw_regs[gi] = value_reg;
      end
   endgenerate

   assign ctrl_o   = rw_regs[0];
   assign a_base_o = rw_regs[1];
   assign b_base_o = rw_regs[2];
   assign c_base_o = rw_regs[3];

   // Sampled before the commit edge, so a same-cycle write reads the old value
   always_comb begin
      rd_data_next = '0;
      if (ar_idx < REG_IDX_W'(NUM_RW_REGS)) begin
         rd_data_next = rw_regs[ar_idx[1:0]];
      end else if (ar_idx == REG_STATUS) begin
         rd_data_next[STATUS_BUSY_BIT] = busy_i;
         rd_data_next[STATUS_DONE_BIT] = done_sticky_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_en_reg    <= 1'b0;
         aw_held_reg     <= 1'b0;
         aw_idx_reg      <= '0;
         w_held_reg      <= 1'b0;
         w_data_reg      <= '0;
         w_strb_reg      <= '0;
         bvalid_reg      <= 1'b0;
         rvalid_reg      <= 1'b0;
         rdata_reg       <= '0;
         start_reg       <= 1'b0;
         done_sticky_reg <= 1'b0;
      end else begin
         ready_en_reg <= 1'b1;

         if (aw_hs) begin
            aw_held_reg <= 1'b1;
            aw_idx_reg  <= s_axi_awaddr[2 +: REG_IDX_W];
         end else if (wr_commit) begin
            aw_held_reg <= 1'b0;
         end

         if (w_hs) begin
            w_held_reg <= 1'b1;
            w_data_reg <= s_axi_wdata;
            w_strb_reg <= s_axi_wstrb;
         end else if (wr_commit) begin
            w_held_reg <= 1'b0;
         end

         if (wr_commit) begin
            bvalid_reg <= 1'b1;
         end else if (bvalid_reg && s_axi_bready) begin
            bvalid_reg <= 1'b0;
         end

         start_reg <= start_next;

         // A done pulse in the clearing cycle must not be lost
         if (done_i) begin
            done_sticky_reg <= 1'b1;
         end else if (status_clr) begin
            done_sticky_reg <= 1'b0;
         end

         if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data_next;
         end else if (rvalid_reg && s_axi_rready) begin
            rvalid_reg <= 1'b0;
         end
      end
   end

endmodule
